// File: rtl/t_switch_rr_pkg.sv
// Shared types for the T-switch node: 2-bit direction codes and a deflection-count helper.
package t_switch_rr_pkg;

  typedef enum logic [1:0] {
    DIR_VOID  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  localparam int STATS_W = 16;

  // Number of packets (0..3) that left on a port other than their decoded one.
  function automatic logic [1:0] deflect_sum(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

endpackage

// File: rtl/t_route_decode.sv
// Destination decode for one T-switch input: maps a leaf address to VOID/LEFT/RIGHT/UP.
module t_route_decode
  import t_switch_rr_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LEVEL  = 0,
  parameter int POS    = 0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              valid,
  output dir_e              dir
);

  localparam logic [ADDR_W-1:0] POS_V = ADDR_W'(POS);

  logic [ADDR_W-1:0] subtree;
  assign subtree = addr >> (LEVEL + 1);

  always_comb begin
    dir = DIR_VOID;
    if (valid) begin
      if (subtree != POS_V) begin
        dir = DIR_UP;
      end else if (addr[LEVEL]) begin
        dir = DIR_RIGHT;
      end else begin
        dir = DIR_LEFT;
      end
    end
  end

endmodule

// File: rtl/t_switch_rr.sv
// Registered bufferless T-switch node with round-robin uplink arbitration.
// Define T_SWITCH_STATS_EN to add the saturating deflect_cnt output.
//
// Handshake: every *_v qualifies its data for exactly one cycle; there is no
// ready, a node never stalls and every valid input appears on one output one
// cycle later.
module t_switch_rr
  import t_switch_rr_pkg::*;
#(
  parameter int P_W    = 49,
  parameter int ADDR_W = 5,
  parameter int LEVEL  = 0,
  parameter int POS    = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [P_W-1:0] l_in,
  input  logic           l_in_v,
  input  logic [P_W-1:0] r_in,
  input  logic           r_in_v,
  input  logic [P_W-1:0] u_in,
  input  logic           u_in_v,
  output logic [P_W-1:0] l_out,
  output logic           l_out_v,
  output logic [P_W-1:0] r_out,
  output logic           r_out_v,
  output logic [P_W-1:0] u_out,
  output logic           u_out_v
`ifdef T_SWITCH_STATS_EN
  ,
  output logic [STATS_W-1:0] deflect_cnt
`endif
);

  localparam bit ROOT = (LEVEL + 1 >= ADDR_W);

  dir_e l_dir, r_dir, u_dir;
  dir_e l_take, r_take, u_take;
  logic free_l, free_r, free_u;
  logic rr_ptr, rr_toggle;
  logic u_v_eff;

  logic [P_W-1:0] nxt_l, nxt_r, nxt_u;
  logic           nxt_l_v, nxt_r_v, nxt_u_v;

  assign u_v_eff = u_in_v && !ROOT;

  t_route_decode #(.ADDR_W(ADDR_W), .LEVEL(LEVEL), .POS(POS)) u_dec_l (
    .addr  (l_in[P_W-1 -: ADDR_W]),
    .valid (l_in_v),
    .dir   (l_dir)
  );

  t_route_decode #(.ADDR_W(ADDR_W), .LEVEL(LEVEL), .POS(POS)) u_dec_r (
    .addr  (r_in[P_W-1 -: ADDR_W]),
    .valid (r_in_v),
    .dir   (r_dir)
  );

  t_route_decode #(.ADDR_W(ADDR_W), .LEVEL(LEVEL), .POS(POS)) u_dec_u (
    .addr  (u_in[P_W-1 -: ADDR_W]),
    .valid (u_v_eff),
    .dir   (u_dir)
  );

  // Stage order matters: each stage only sees outputs the earlier ones left free.
  always_comb begin
    l_take    = DIR_VOID;
    r_take    = DIR_VOID;
    u_take    = DIR_VOID;
    free_l    = 1'b1;
    free_r    = 1'b1;
    free_u    = !ROOT;
    rr_toggle = 1'b0;

    if (l_dir == DIR_LEFT) begin
      l_take = DIR_LEFT;
      free_l = 1'b0;
    end
    if (r_dir == DIR_RIGHT) begin
      r_take = DIR_RIGHT;
      free_r = 1'b0;
    end
    if (u_dir == DIR_UP) begin
      u_take = DIR_UP;
      free_u = 1'b0;
    end

    if (u_dir == DIR_LEFT) begin
      if (free_l) begin
        u_take = DIR_LEFT;
        free_l = 1'b0;
      end else begin
        u_take = DIR_UP;
        free_u = 1'b0;
      end
    end else if (u_dir == DIR_RIGHT) begin
      if (free_r) begin
        u_take = DIR_RIGHT;
        free_r = 1'b0;
      end else begin
        u_take = DIR_UP;
        free_u = 1'b0;
      end
    end

    if (free_u && l_dir == DIR_UP && r_dir == DIR_UP) begin
      rr_toggle = 1'b1;
      free_u    = 1'b0;
      if (rr_ptr) r_take = DIR_UP;
      else        l_take = DIR_UP;
    end else if (free_u && l_dir == DIR_UP) begin
      l_take = DIR_UP;
      free_u = 1'b0;
    end else if (free_u && r_dir == DIR_UP) begin
      r_take = DIR_UP;
      free_u = 1'b0;
    end

    if (l_take == DIR_VOID && l_dir == DIR_RIGHT && free_r) begin
      l_take = DIR_RIGHT;
      free_r = 1'b0;
    end
    if (r_take == DIR_VOID && r_dir == DIR_LEFT && free_l) begin
      r_take = DIR_LEFT;
      free_l = 1'b0;
    end

    // Deflection fallback; u is always placed by the downlink stage.
    if (l_take == DIR_VOID && l_dir != DIR_VOID) begin
      if (free_l) begin
        l_take = DIR_LEFT;
        free_l = 1'b0;
      end else if (free_r) begin
        l_take = DIR_RIGHT;
        free_r = 1'b0;
      end else if (free_u) begin
        l_take = DIR_UP;
        free_u = 1'b0;
      end
    end
    if (r_take == DIR_VOID && r_dir != DIR_VOID) begin
      if (free_r) begin
        r_take = DIR_RIGHT;
        free_r = 1'b0;
      end else if (free_l) begin
        r_take = DIR_LEFT;
        free_l = 1'b0;
      end else if (free_u) begin
        r_take = DIR_UP;
        free_u = 1'b0;
      end
    end
  end

  always_comb begin
    nxt_l_v = (l_take == DIR_LEFT) || (r_take == DIR_LEFT) || (u_take == DIR_LEFT);
    nxt_r_v = (l_take == DIR_RIGHT) || (r_take == DIR_RIGHT) || (u_take == DIR_RIGHT);
    nxt_u_v = (l_take == DIR_UP) || (r_take == DIR_UP) || (u_take == DIR_UP);

    nxt_l = '0;
    if (l_take == DIR_LEFT)      nxt_l = l_in;
    else if (r_take == DIR_LEFT) nxt_l = r_in;
    else if (u_take == DIR_LEFT) nxt_l = u_in;

    nxt_r = '0;
    if (l_take == DIR_RIGHT)      nxt_r = l_in;
    else if (r_take == DIR_RIGHT) nxt_r = r_in;
    else if (u_take == DIR_RIGHT) nxt_r = u_in;

    nxt_u = '0;
    if (l_take == DIR_UP)      nxt_u = l_in;
    else if (r_take == DIR_UP) nxt_u = r_in;
    else if (u_take == DIR_UP) nxt_u = u_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_out   <= '0;
      l_out_v <= 1'b0;
      r_out   <= '0;
      r_out_v <= 1'b0;
      u_out   <= '0;
      u_out_v <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      l_out   <= nxt_l;
      l_out_v <= nxt_l_v;
      r_out   <= nxt_r;
      r_out_v <= nxt_r_v;
      u_out   <= nxt_u;
      u_out_v <= nxt_u_v;
      if (rr_toggle) rr_ptr <= ~rr_ptr;
    end
  end

`ifdef T_SWITCH_STATS_EN
  logic [1:0]         n_defl;
  logic [STATS_W:0]   defl_sum;

  assign n_defl   = deflect_sum(l_take != l_dir, r_take != r_dir, u_take != u_dir);
  assign defl_sum = {1'b0, deflect_cnt} + (STATS_W + 1)'(n_defl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deflect_cnt <= '0;
    end else if (defl_sum[STATS_W]) begin
      deflect_cnt <= '1;
    end else begin
      deflect_cnt <= defl_sum[STATS_W-1:0];
    end
  end
`else
  // Statistics disabled: the switching path above is the whole node.
`endif

endmodule
